// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one uart_tx among NREQ byte requesters.
// Winner's byte/parity enable are latched at grant and held while uart_ap_ready=1.
// Once uart_tx reports completion the requester is acked, then the block waits for
// uart_tx to go idle again.
// Optional: define UART_SCHED_TMO_EN to add a SEND watchdog of TMO_CYCLES cycles.
module uart_tx_sched #(
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    ap_rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_pairty,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    uart_ap_ready,
  output logic [7:0]              uart_data,
  output logic                    uart_pairty,
  input  logic                    uart_ap_vaild,
  output logic                    tmo_err
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n, grant_n, win, ptr_after;
  logic            win_vld;
  logic [NREQ-1:0] ack_n;
  logic [7:0]      data_n;
  logic            par_n;

`ifdef UART_SCHED_TMO_EN
  localparam int CW = $clog2(TMO_CYCLES);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_n, tmo_q;
`endif

  assign busy          = (state != IDLE);
  assign uart_ap_ready = (state == SEND);
  // pointer skips past the requester just served, so it gets lowest priority next
  assign ptr_after     = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;

  // first asserted req searching upward from rr_ptr with wrap
  always_comb begin
    int idx;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    grant_n  = grant_id;
    data_n   = uart_data;
    par_n    = uart_pairty;
    ack_n    = '0;
`ifdef UART_SCHED_TMO_EN
    tmo_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        // a high uart_ap_vaild here is a stale frame: hold off until uart_tx is idle
        if (win_vld && !uart_ap_vaild) begin
          state_n = SEND;
          grant_n = win;
          data_n  = req_data[8*int'(win) +: 8];
          par_n   = req_pairty[win];
        end
      end
      SEND: begin
        if (uart_ap_vaild) begin
          state_n         = DRAIN;
          ack_n[grant_id] = 1'b1;
          rr_ptr_n        = ptr_after;
        end
`ifdef UART_SCHED_TMO_EN
        else if (tmo_cnt == CW'(TMO_CYCLES-1)) begin
          state_n  = DRAIN;
          tmo_n    = 1'b1;
          rr_ptr_n = ptr_after;
        end
`endif
      end
      DRAIN: begin
        if (!uart_ap_vaild) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      uart_data   <= 8'h00;
      uart_pairty <= 1'b0;
      ack         <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      grant_id    <= grant_n;
      uart_data   <= data_n;
      uart_pairty <= par_n;
      ack         <= ack_n;
    end
  end

`ifdef UART_SCHED_TMO_EN
  // SEND cycle counter; held at zero outside SEND so each SEND entry starts from 0
  always_ff @(posedge clk or posedge ap_rst) begin
    if (ap_rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == SEND) ? tmo_cnt + 1'b1 : '0;
      tmo_q   <= tmo_n;
    end
  end
  assign tmo_err = tmo_q;
`else
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx model plus a round-robin reference model.
module tb_uart_tx_sched;
  localparam int NREQ = 4;

  logic                    clk = 1'b0;
  logic                    ap_rst = 1'b0;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ*8-1:0]       req_data = '0;
  logic [NREQ-1:0]         req_pairty = '0;
  logic [NREQ-1:0]         ack;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    uart_ap_ready;
  logic [7:0]              uart_data;
  logic                    uart_pairty;
  logic                    uart_ap_vaild;
  logic                    tmo_err;

  int n_chk = 0;
  int n_fail = 0;
  int mdl_ptr = 0;

  uart_tx_sched #(.NREQ(NREQ), .TMO_CYCLES(16)) dut (
    .clk(clk), .ap_rst(ap_rst), .req(req), .req_data(req_data), .req_pairty(req_pairty),
    .ack(ack), .busy(busy), .grant_id(grant_id), .uart_ap_ready(uart_ap_ready),
    .uart_data(uart_data), .uart_pairty(uart_pairty), .uart_ap_vaild(uart_ap_vaild),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // uart_tx model: start, 8 data bits LSB first, optional even parity, stop; then done
  typedef struct { logic [7:0] d; logic pen; logic pb; int len; logic ok; } frame_t;
  frame_t fq[$];
  frame_t cur;
  int     tx_pos = -1;
  logic   tx_en = 1'b1;
  logic   tx_vaild = 1'b0;
  logic   vaild_force = 1'b0;
  assign uart_ap_vaild = tx_en ? tx_vaild : vaild_force;

  always @(posedge clk) begin
    if (tx_pos < 0) begin
      if (tx_vaild && !uart_ap_ready) tx_vaild <= 1'b0;
      else if (tx_en && uart_ap_ready && !tx_vaild) begin
        cur = '{d: 8'h00, pen: uart_pairty, pb: 1'b0, len: 1, ok: 1'b1};
        tx_pos = 1;
      end
    end else begin
      if (!uart_ap_ready || uart_pairty !== cur.pen) cur.ok = 1'b0;
      if (tx_pos >= 1 && tx_pos <= 8) cur.d[tx_pos-1] = uart_data[tx_pos-1];
      if (tx_pos == 9 && cur.pen) cur.pb = ^uart_data;
      cur.len++;
      if (tx_pos == (cur.pen ? 10 : 9)) begin
        fq.push_back(cur);
        tx_vaild <= 1'b1;
        tx_pos = -1;
      end else tx_pos++;
    end
  end

  // reference arbiter: pending requester with smallest rotational distance from the pointer
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    int best = -1, bd = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (m[i] && ((i - p + NREQ) % NREQ) < bd) begin
        bd = (i - p + NREQ) % NREQ;
        best = i;
      end
    return best;
  endfunction

  // wait for grant of `win`, its completion ack, and its transmitted frame
  task automatic serve(input int win, output frame_t fr);
    bit got = 0;
    int tv = -1, ta = -1;
    logic [7:0] ed;
    logic ep;
    fr = '{d: 8'h00, pen: 1'b0, pb: 1'b0, len: 0, ok: 1'b0};
    for (int i = 0; i < 100; i++) begin
      if (uart_ap_ready === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL grant_timeout: no uart_ap_ready, want grant %0d", win); return; end
    ed = req_data[8*win +: 8];
    ep = req_pairty[win];
    n_chk++;
    if (grant_id !== win[1:0]) begin n_fail++; $display("FAIL grant_id: got %0d want %0d", grant_id, win); end
    n_chk++;
    if ({uart_pairty, uart_data} !== {ep, ed}) begin
      n_fail++; $display("FAIL latch: got %b/%h want %b/%h", uart_pairty, uart_data, ep, ed);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack !== '0) begin ta = i; break; end
      if (uart_ap_vaild && tv < 0) tv = i;
    end
    n_chk++;
    if (ta < 0 || ta != tv + 1) begin n_fail++; $display("FAIL ack_latency: ack at %0d vaild at %0d", ta, tv); end
    n_chk++;
    if (ack !== (NREQ'(1) << win)) begin n_fail++; $display("FAIL ack_onehot: got %b want grant %0d", ack, win); end
    n_chk++;
    if ({uart_ap_ready, busy, tmo_err} !== 3'b010) begin
      n_fail++; $display("FAIL ack_state: ready/busy/tmo got %b want 010", {uart_ap_ready, busy, tmo_err});
    end
    n_chk++;
    if (fq.size() == 0) begin n_fail++; $display("FAIL frame_missing: grant %0d", win); end
    else begin
      fr = fq.pop_front();
      n_chk++;
      if (fr.d !== ed || fr.pen !== ep || !fr.ok || (ep && fr.pb !== ^ed) || fr.len != (ep ? 11 : 10)) begin
        n_fail++;
        $display("FAIL frame: got d=%h pen=%b pb=%b len=%0d ok=%b want d=%h pen=%b", fr.d, fr.pen, fr.pb, fr.len, fr.ok, ed, ep);
      end
    end
    mdl_ptr = (win + 1) % NREQ;
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && !uart_ap_vaild) begin idle = 1; break; end
    end
    n_chk++;
    if (!idle) begin n_fail++; $display("FAIL %s_idle: busy=%b stays high", nm, busy); end
  endtask

  task automatic do_reset();
    @(negedge clk); ap_rst = 1'b1; req = '0;
    @(negedge clk); @(negedge clk); ap_rst = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_reset();
    #1 ap_rst = 1'b1;
    #2;
    n_chk++;
    if ({ack, busy, grant_id, uart_ap_ready, uart_data, uart_pairty, tmo_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: ack=%b busy=%b gid=%0d rdy=%b data=%h par=%b tmo=%b want all 0",
                         ack, busy, grant_id, uart_ap_ready, uart_data, uart_pairty, tmo_err);
    end
    @(negedge clk); @(negedge clk); ap_rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || uart_ap_ready !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    frame_t fr;
    int w;
    req_data[23:16] = 8'hA5; req_pairty = 4'b0100; req = 4'b0100;
    w = pick(req, mdl_ptr);
    @(negedge clk);
    n_chk++;
    if (uart_ap_ready !== 1'b1 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_latency: ready=%b gid=%0d want 1/2", uart_ap_ready, grant_id);
    end
    serve(w, fr);
    req = '0;
    n_chk++;
    if (fr.pb !== 1'b0 || fr.d !== 8'hA5) begin n_fail++; $display("FAIL single_parity: pb=%b d=%h want 0/a5", fr.pb, fr.d); end
    wait_idle("single");
  endtask

  task automatic test_round_robin();
    frame_t fr;
    int w;
    do_reset();
    req_data = 32'h44_33_22_11; req_pairty = 4'b1001; req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      w = pick(req, mdl_ptr);
      serve(w, fr);
    end
    req = '0;
    wait_idle("rr");
  endtask

  task automatic test_drop_req();
    frame_t fr;
    bit got = 0, bad = 0;
    int w;
    req_data = 32'hDE_AD_BE_EF; req_pairty = 4'b0010; req = 4'b0010;
    w = pick(req, mdl_ptr);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_ap_ready) begin got = 1; break; end
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL drop_grant: no grant for requester %0d", w); end
    req = 4'b0001;                      // requester 1 drops after grant, 0 pulses while busy
    @(negedge clk); req = '0;
    serve(w, fr);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uart_ap_ready || ack !== '0) bad = 1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL drop_pulse: requester 0 served after 1-cycle pulse, want none"); end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    int w;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_ap_ready) begin got = 1; break; end
    end
    repeat (5) @(negedge clk);
    #2 ap_rst = 1'b1;
    #1;
    n_chk++;
    if ({uart_ap_ready, ack, busy, grant_id} !== '0 || !got) begin
      n_fail++; $display("FAIL reset_mid: ready=%b ack=%b busy=%b gid=%0d want 0", uart_ap_ready, ack, busy, grant_id);
    end
    @(negedge clk);
    ap_rst = 1'b0; mdl_ptr = 0; req = 4'b1000;
    w = pick(req, mdl_ptr);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_ap_ready) begin got = 1; break; end
    end
    n_chk++;
    if (!got || grant_id !== w[1:0]) begin n_fail++; $display("FAIL reset_regrant: gid=%0d want %0d", grant_id, w); end
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack !== '0) begin got = 1; break; end
    end
    n_chk++;
    if (ack !== 4'b1000) begin n_fail++; $display("FAIL reset_ack: got %b want 1000", ack); end
    req = '0;
    mdl_ptr = (w + 1) % NREQ;
    wait_idle("reset_mid");
    repeat (3) @(negedge clk);
    fq.delete();
  endtask

  task automatic test_stale_vaild();
    bit bad = 0;
    tx_en = 1'b0; vaild_force = 1'b1; req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_ap_ready || busy) bad = 1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL stale_grant: granted while uart_ap_vaild high, want no grant"); end
    vaild_force = 1'b0;
    @(negedge clk);
    n_chk++;
    if (uart_ap_ready !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL stale_release: ready=%b gid=%0d want 1/0", uart_ap_ready, grant_id);
    end
    repeat (3) @(negedge clk);
    vaild_force = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL stale_ack: got %b want 0001", ack); end
    req = '0; vaild_force = 1'b0;
    mdl_ptr = 1;
    wait_idle("stale");
    tx_en = 1'b1;
  endtask

  task automatic test_random();
    frame_t fr;
    int w;
    logic [NREQ-1:0] m;
    req_data = {$urandom}; req_pairty = NREQ'($urandom); req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      w = pick(req, mdl_ptr);
      serve(w, fr);
      m = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (m == '0) m = NREQ'(1) << $urandom_range(0, NREQ - 1);
      req = m; req_data = {$urandom}; req_pairty = NREQ'($urandom);
    end
    req = '0;
    wait_idle("random");
  endtask

`ifdef UART_SCHED_TMO_EN
  task automatic test_timeout();
    int ir = -1, it = -1, w;
    bit acked = 0;
    tx_en = 1'b0; vaild_force = 1'b0; req = 4'b0100;
    w = pick(req, mdl_ptr);
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (uart_ap_ready && ir < 0) ir = i;
      if (ack !== '0) acked = 1;
      if (tmo_err) begin it = i; break; end
    end
    req = '0;
    n_chk++;
    if (ir != 1 || it - ir != 16) begin n_fail++; $display("FAIL tmo_latency: ready at %0d tmo at %0d want 1/17", ir, it); end
    n_chk++;
    if (acked) begin n_fail++; $display("FAIL tmo_ack: ack seen, want none"); end
    mdl_ptr = (w + 1) % NREQ;
    wait_idle("tmo");
    tx_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_req();
    test_reset_mid();
    test_stale_vaild();
    test_random();
`ifdef UART_SCHED_TMO_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
